// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, instruction field positions, ALU opcodes and the decoded-field record
package alu_pkg;
  localparam int IW = 19;
  localparam int DW = 8;
  localparam int S_POS = 18;
  localparam int U_POS = 17;
  localparam int ACODE_LSB = 14;
  localparam int SCODE_LSB = 12;
  localparam int RD_LSB = 9;
  localparam int RS_LSB = 6;
  localparam int RT_LSB = 3;
  localparam int SHAMT_LSB = 0;
  typedef enum logic [2:0] {
    ADD = 3'b000, ADC = 3'b001, SUB = 3'b010, SBC = 3'b011,
    AND = 3'b100, OR = 3'b101, XOR = 3'b110, NAND = 3'b111
  } acode_e;
  typedef enum logic [1:0] {SHL = 2'b00, SAR = 2'b01, ROL = 2'b10, ROR = 2'b11} scode_e;
  typedef struct packed {
    logic       s;
    logic       u;
    logic [2:0] acode;
    logic [1:0] scode;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] shamt;
  } dec_t;
endpackage

// File: rtl/hazard_unit.sv
// hazard_unit: RAW check of the offered instruction's sources against the ops held in D and W
module hazard_unit (
  input  logic [2:0] rs_i,
  input  logic [2:0] rt_i,
  input  logic       use_rt_i,
  input  logic       d_valid_i,
  input  logic [2:0] d_rd_i,
  input  logic       w_we_i,
  input  logic [2:0] w_rd_i,
  output logic       ready_o
);
  logic rs_hit, rt_hit;
  assign rs_hit = rs_i != '0 && ((d_valid_i && rs_i == d_rd_i) || (w_we_i && rs_i == w_rd_i));
  assign rt_hit = use_rt_i && rt_i != '0 && ((d_valid_i && rt_i == d_rd_i) || (w_we_i && rt_i == w_rd_i));
  assign ready_o = !(rs_hit || rt_hit);
endmodule

// File: rtl/alu_decode.sv
// alu_decode: decode/issue stage D, flag register and writeback stage W around the 8-bit ALU
module alu_decode
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  input  logic [IW-1:0] instr,
  output logic          instr_ready,
  output logic          d_valid,
  output logic          is_shift,
  output logic          update_z_c,
  output logic [1:0]    scode,
  output logic [2:0]    acode,
  output logic          carry_in,
  output logic [2:0]    rs,
  output logic [2:0]    rt,
  output logic          b_sel,
  output logic [DW-1:0] b_imm,
  input  logic [DW-1:0] alu_r,
  input  logic          alu_zero,
  input  logic          alu_carry,
  output logic          w_valid,
  output logic          w_we,
  output logic [2:0]    w_rd,
  output logic [DW-1:0] w_data,
  output logic          z_flag,
  output logic          c_flag
);
  dec_t ins, d_q, d_d;
  logic d_valid_q, d_valid_d, accept;
  logic w_valid_q, w_valid_d, w_we_q, w_we_d;
  logic [2:0] w_rd_q, w_rd_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic z_q, z_d, c_q, c_d, flag_upd, c_upd;
  always_comb begin
    ins.s = instr[S_POS];
    ins.u = instr[U_POS];
    ins.acode = instr[ACODE_LSB +: 3];
    ins.scode = instr[SCODE_LSB +: 2];
    ins.rd = instr[RD_LSB +: 3];
    ins.rs = instr[RS_LSB +: 3];
    ins.rt = instr[RT_LSB +: 3];
    ins.shamt = instr[SHAMT_LSB +: 3];
  end
  hazard_unit u_hazard (
    .rs_i      (ins.rs),
    .rt_i      (ins.rt),
    .use_rt_i  (!ins.s),
    .d_valid_i (d_valid_q),
    .d_rd_i    (d_q.rd),
    .w_we_i    (w_we_q),
    .w_rd_i    (w_rd_q),
    .ready_o   (instr_ready)
  );
  assign accept = instr_valid && instr_ready;
  // Carry survives logic ops and shift-by-0; only Z follows every flag-updating op
  always_comb begin
    d_d = accept ? ins : d_q;
    d_valid_d = accept;
    w_valid_d = d_valid_q;
    w_we_d = d_valid_q && d_q.rd != '0;
    w_rd_d = d_q.rd;
    w_data_d = alu_r;
    flag_upd = d_valid_q && d_q.u;
    c_upd = flag_upd && (d_q.s ? d_q.shamt != '0 : !d_q.acode[2]);
    z_d = flag_upd ? alu_zero : z_q;
    c_d = c_upd ? alu_carry : c_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= '0;
      d_valid_q <= 1'b0;
      w_valid_q <= 1'b0;
      w_we_q <= 1'b0;
      w_rd_q <= '0;
      w_data_q <= '0;
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      d_q <= d_d;
      d_valid_q <= d_valid_d;
      w_valid_q <= w_valid_d;
      w_we_q <= w_we_d;
      w_rd_q <= w_rd_d;
      w_data_q <= w_data_d;
      z_q <= z_d;
      c_q <= c_d;
    end
  end
  assign d_valid = d_valid_q;
  assign is_shift = d_q.s;
  assign update_z_c = d_q.u;
  assign scode = d_q.scode;
  assign acode = d_q.acode;
  assign rs = d_q.rs;
  assign rt = d_q.rt;
  assign b_sel = d_q.s;
  assign b_imm = {{(DW-3){1'b0}}, d_q.shamt};
  assign carry_in = c_q;
  assign w_valid = w_valid_q;
  assign w_we = w_we_q;
  assign w_rd = w_rd_q;
  assign w_data = w_data_q;
  assign z_flag = z_q;
  assign c_flag = c_q;
endmodule

// File: doc/alu_decode.md
# alu_decode

Decode-and-issue stage that sits in front of the 8-bit combinational ALU. It accepts 19-bit instruction words over a valid/ready handshake and registers the decoded ALU control fields into stage D. It supplies the architectural carry to the ALU, holds the Z/C flag register, and captures ALU results into stage W for register-file writeback. It stalls the instruction stream on read-after-write hazards against D and W.

## Interface
- `IW`, 19: instruction width.
- `DW`, 8: data width; matches the ALU.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_valid` in 1: `instr` is presented.
- `instr` in IW: [18] S (shift), [17] U (update flags), [16:14] acode, [13:12] scode, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] shamt.
- `instr_ready` out 1: combinational; low on hazard.
- `d_valid` out 1: stage D holds an op; ALU output is meaningful.
- `is_shift`, `update_z_c` out 1 each: to the ALU.
- `scode` out 2, `acode` out 3: to the ALU.
- `carry_in` out 1: equals `c_flag`.
- `rs`, `rt` out 3 each: register-file read addresses.
- `b_sel` out 1: 1 selects `b_imm` as ALU B; 0 selects rt data.
- `b_imm` out DW: shamt zero-extended.
- `alu_r` in DW, `alu_zero` in 1, `alu_carry` in 1: from the ALU, sampled when `d_valid`.
- `w_valid`, `w_we` out 1 each: writeback stage.
- `w_rd` out 3, `w_data` out DW: writeback address and data.
- `z_flag`, `c_flag` out 1 each: architectural flags.

## Operation
- Accept: a transfer happens on a rising edge when `instr_valid && instr_ready`. The decoded fields load into D and `d_valid` is set to 1. Otherwise `d_valid` is set to 0, which inserts a bubble.
- Field decode:
  - `b_sel` = S.
  - `b_imm` = {5'b0, shamt}.
  - `is_shift` = S.
  - `update_z_c` = U.
  - rs, rt, acode, scode pass through unchanged.
- D→W: every edge, W loads D. The loaded values are `w_valid` = `d_valid`, `w_rd` = rd, `w_data` = `alu_r`, and `w_we` = `d_valid && rd != 0`.
- Register r0 is hardwired to zero. It is never written and never causes a hazard.
- Flags update on the edge where `d_valid && U`:
  - `z_flag` <= `alu_zero`.
  - `c_flag` <= `alu_carry` only for arithmetic ops (S=0, acode[2]=0) or for shifts with shamt != 0.
  - `c_flag` is held for logic ops (acode 1xx) and for shift by 0.
- Hazard, combinational:
  - Source set = {rs} ∪ ({rt} if S=0).
  - `instr_ready` = 0 when any nonzero source equals the rd of a valid D op or a valid W op with `w_we`. Otherwise `instr_ready` = 1.
  - `instr_ready` is not gated by `instr_valid`.
- No downstream backpressure: D and W always advance.
- Reset (sync): `d_valid`, `w_valid`, `w_we`, `z_flag` and `c_flag` reset to 0. All field registers reset to 0, so `b_sel` = 0 and `carry_in` = 0. A reset asserted mid-stream discards the ops in D and W, and no flag update occurs on that edge.

## Timing
- Issue latency: the instruction is accepted at edge N, its ALU control is valid in cycle N+1, and it is in W in cycle N+2.
- Flags written at edge N+1 are visible on `carry_in` in cycle N+1 after that edge. A back-to-back ADC/SBC therefore sees the previous op's carry with no stall.
- A RAW hazard on an op in D costs 2 stall cycles; a hazard on an op in W costs 1. The dependent instruction issues at the earliest edge after the producer leaves W.
- Hazard evaluation in the same cycle uses the current D/W contents, not the next-state contents.
- Throughput is 1 instruction per cycle when there are no hazards.

## Structure
- Shared package `alu_pkg`:
  - acode constants ADD=000, ADC=001, SUB=010, SBC=011, AND=100, OR=101, XOR=110, NAND=111.
  - scode constants SHL=00, SAR=01, ROL=10, ROR=11.
  - instruction field bit positions.
  - widths IW and DW.
- Sub-module `hazard_unit`: purely combinational source-versus-D/W compare that drives `instr_ready`.

## Test plan
- Reset, then ADD r1,r2,r3 with U=1 and the ALU returning r=8'h00, zero=1, carry=1 → `d_valid`=1 at N+1; `w_we`=1, `w_rd`=1 at N+2; `z_flag`=1, `c_flag`=1.
- With `c_flag`=1, ADC issued back-to-back → `carry_in`=1 in the ADC's D cycle; `instr_ready` stays 1 throughout.
- AND with U=1, ALU zero=0, carry=0, and `c_flag`=1 beforehand → `z_flag`=0, `c_flag` stays 1. SHL shamt=0 with U=1 → `c_flag` unchanged.
- ADD r4 followed by OR rs=r4 → `instr_ready`=0 for 2 cycles and OR issues on the third. Shift with rt=r4 (rt unused) → no stall. Writing rd=r0 → no stall and `w_we`=0.
- `rst` asserted while ops are in D and W → next cycle `d_valid`=`w_valid`=`w_we`=0, flags=0, `instr_ready`=1.
- Random 1000-op stream checked against a reference model → every accepted op appears in W exactly once and in order, with correct flags.
